// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes SPI command words into single-port RAM accesses.
// Define SPI_MEM_CTRL_AUTO_INC_EN to step addresses after each access.
module spi_mem_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [9:0]           rx_data,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 cmd_drop
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t state, state_d;

    logic                 rx_valid_q;
    logic                 cmd_evt;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] pay_addr;
    logic [ADDR_SIZE-1:0] wr_addr, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr, rd_addr_d;
    logic [ADDR_SIZE-1:0] mem_addr_d;
    logic [7:0]           mem_wdata_d;
    logic [7:0]           tx_data_d;
    logic                 mem_en_d;
    logic                 mem_we_d;
    logic                 tx_valid_d;
    logic                 cmd_drop_d;

    assign cmd_evt  = rx_valid & ~rx_valid_q;
    assign cmd      = rx_data[9:8];
    assign pay_addr = rx_data[ADDR_SIZE-1:0];

    always_comb begin
        state_d     = state;
        wr_addr_d   = wr_addr;
        rd_addr_d   = rd_addr;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        tx_data_d   = tx_data;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        tx_valid_d  = 1'b0;
        cmd_drop_d  = cmd_evt && (state != IDLE);

        unique case (state)
            IDLE: begin
                if (cmd_evt) begin
                    unique case (cmd)
                        2'b00: wr_addr_d = pay_addr;
                        2'b10: rd_addr_d = pay_addr;
                        2'b01: begin
                            state_d     = WR;
                            mem_en_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_addr;
                            mem_wdata_d = rx_data[7:0];
                        end
                        2'b11: begin
                            state_d    = RD_REQ;
                            mem_en_d   = 1'b1;
                            mem_addr_d = rd_addr;
                        end
                    endcase
                end
            end
            WR: begin
                state_d = IDLE;
`ifdef SPI_MEM_CTRL_AUTO_INC_EN
                wr_addr_d = wr_addr + ADDR_SIZE'(1);
`endif
            end
            RD_REQ: begin
                state_d = RD_WAIT;
`ifdef SPI_MEM_CTRL_AUTO_INC_EN
                rd_addr_d = rd_addr + ADDR_SIZE'(1);
`endif
            end
            RD_WAIT: begin
                state_d    = IDLE;
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
            end
        endcase
    end

    // Outputs are registered from their next-cycle values so strobes
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            cmd_drop   <= 1'b0;
        end else begin
            state      <= state_d;
            rx_valid_q <= rx_valid;
            wr_addr    <= wr_addr_d;
            rd_addr    <= rd_addr_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            busy       <= (state_d != IDLE);
            cmd_drop   <= cmd_drop_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed plus random command streams against a
// transaction-level model of the sequencer and a behavioural RAM.
module tb_spi_mem_ctrl;

    localparam int AW = 8;
    localparam int N  = 4096;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [9:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          cmd_drop;

    spi_mem_ctrl #(.ADDR_SIZE(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_drop  (cmd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural RAM: read data appears one cycle after the strobe
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // expected outputs per cycle index
    bit         exp_en   [N];
    bit         exp_we   [N];
    logic [7:0] exp_addr [N];
    logic [7:0] exp_wd   [N];
    bit         exp_busy [N];
    bit         exp_drop [N];
    bit         exp_txv  [N];
    logic [7:0] exp_txd  [N];

    logic [7:0] mmem [256];
    int         m_wa;
    int         m_ra;
    int         free_at;
    bit         prev_v;
    logic [7:0] tx_hold;
    int         n;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h",
                     tag, n, got, want);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [9:0] d);
        int c;
        int p;
        if (r) begin
            for (int k = 1; k <= 3; k++) begin
                exp_en[n+k]   = 0;
                exp_we[n+k]   = 0;
                exp_busy[n+k] = 0;
                exp_drop[n+k] = 0;
                exp_txv[n+k]  = 0;
            end
            m_wa    = 0;
            m_ra    = 0;
            free_at = n + 1;
            prev_v  = 0;
            tx_hold = 8'h00;
            return;
        end
        c = int'(d[9:8]);
        p = int'(d[7:0]) % (1 << AW);
        if (v && !prev_v) begin
            if (n < free_at) begin
                exp_drop[n+1] = 1;
            end else if (c == 0) begin
                m_wa = p;
            end else if (c == 2) begin
                m_ra = p;
            end else if (c == 1) begin
                exp_en[n+1]   = 1;
                exp_we[n+1]   = 1;
                exp_addr[n+1] = 8'(m_wa);
                exp_wd[n+1]   = d[7:0];
                exp_busy[n+1] = 1;
                mmem[m_wa]    = d[7:0];
                free_at       = n + 2;
`ifdef SPI_MEM_CTRL_AUTO_INC_EN
                m_wa = (m_wa + 1) % (1 << AW);
`endif
            end else begin
                exp_en[n+1]   = 1;
                exp_we[n+1]   = 0;
                exp_addr[n+1] = 8'(m_ra);
                exp_busy[n+1] = 1;
                exp_busy[n+2] = 1;
                exp_txv[n+3]  = 1;
                exp_txd[n+3]  = mmem[m_ra];
                free_at       = n + 3;
`ifdef SPI_MEM_CTRL_AUTO_INC_EN
                m_ra = (m_ra + 1) % (1 << AW);
`endif
            end
        end
        prev_v = v;
    endtask

    task automatic step(input logic r, input logic v, input logic [9:0] d);
        @(negedge clk);
        if (exp_txv[n]) tx_hold = exp_txd[n];
        chk("mem_en", 32'(mem_en), 32'(exp_en[n]));
        chk("mem_we", 32'(mem_we), 32'(exp_we[n]));
        if (exp_en[n]) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr[n]));
            if (exp_we[n]) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd[n]));
        end
        chk("busy", 32'(busy), 32'(exp_busy[n]));
        chk("cmd_drop", 32'(cmd_drop), 32'(exp_drop[n]));
        chk("tx_valid", 32'(tx_valid), 32'(exp_txv[n]));
        chk("tx_data", 32'(tx_data), 32'(tx_hold));
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        model(r, v, d);
        n++;
    endtask

    task automatic pulse(input logic [1:0] c, input logic [7:0] p);
        step(1'b0, 1'b1, {c, p});
        step(1'b0, 1'b0, {c, p});
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0, 10'h000);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 10'h000);
        step(1'b1, 1'b0, 10'h000);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        n         = 0;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        mem_rdata = '0;
        m_wa      = 0;
        m_ra      = 0;
        free_at   = 0;
        prev_v    = 0;
        tx_hold   = 8'h00;
        for (int i = 0; i < N; i++) begin
            exp_en[i]   = 0;
            exp_we[i]   = 0;
            exp_addr[i] = '0;
            exp_wd[i]   = '0;
            exp_busy[i] = 0;
            exp_drop[i] = 0;
            exp_txv[i]  = 0;
            exp_txd[i]  = '0;
        end
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'($urandom);
            mmem[i] = ram[i];
        end

        do_reset();
        // read before any address set: address 0
        pulse(2'b11, 8'h00);
        idle(3);

        // write then read back
        pulse(2'b00, 8'h12);
        pulse(2'b01, 8'hA5);
        pulse(2'b10, 8'h12);
        pulse(2'b11, 8'h00);
        idle(3);

        // held rx_valid: one write only
        repeat (5) step(1'b0, 1'b1, {2'b01, 8'h3C});
        idle(3);

        // busy drop with wr_addr left untouched
        do_reset();
        step(1'b0, 1'b1, {2'b11, 8'h00});
        step(1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b1, {2'b00, 8'h55});
        step(1'b0, 1'b0, 10'h000);
        idle(2);
        pulse(2'b01, 8'h77);
        idle(2);

        // reset in the RD_WAIT cycle
        pulse(2'b11, 8'h00);
        step(1'b1, 1'b0, 10'h000);
        idle(3);

        // address at the top of the range
        pulse(2'b00, 8'hFF);
        pulse(2'b01, 8'h11);
        pulse(2'b01, 8'h22);
        pulse(2'b10, 8'hFF);
        pulse(2'b11, 8'h00);
        idle(2);
        pulse(2'b11, 8'h00);
        idle(3);

        // reset released with rx_valid already high
        step(1'b1, 1'b1, {2'b01, 8'h5A});
        step(1'b0, 1'b1, {2'b01, 8'h5A});
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 10'($urandom));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
